uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Upstream stage of the UART pair: buffers bytes from the host in a FIFO and
//  hands them to one UART transmitter (data/up_data) one at a time, pacing on the
//  UART's busy flag. Output data/up_data wire directly to the UART's data/up_data.
//  Lets the host burst bytes without tracking frame timing.
// PARAMETERS
//  N        8    data width; must match the UART's N
//  DEPTH    16   FIFO entries; power of 2, >= 2
//  BUSY_TMO 15   max cycles WAIT_BUSY waits for uart_busy to rise before giving up
//  GAP      0    idle cycles forced between uart_busy fall and next up_data pulse
// PORTS
//  clk        in   1                 system clock, rising edge
//  rst        in   1                 asynchronous reset, active-high
//  wr_en      in   1                 host write strobe
//  wr_data    in   N                 host byte
//  full       out  1                 FIFO full; wr_en while full is dropped
//  empty      out  1                 FIFO empty
//  count      out  $clog2(DEPTH)+1   FIFO occupancy, 0..DEPTH
//  uart_busy  in   1                 UART transmitter busy (frame in flight)
//  data       out  N                 byte to UART; held until next pulse
//  up_data    out  1                 one-cycle load pulse to UART
//  tx_active  out  1                 high whenever FSM is not IDLE
//  ovf        out  1                 sticky overflow flag (only with UART_FEED_OVF_EN)
// BEHAVIOUR
//  Reset (async): FIFO flushed, ptrs=0, count=0, empty=1, full=0, data=0,
//   up_data=0, tx_active=0, ovf=0, FSM=IDLE. Reset mid-frame: buffered bytes lost,
//   up_data drops immediately; no recovery of the frame the UART is sending.
//  FIFO: wr/rd pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count tracks
//   occupancy. full=(count==DEPTH), empty=(count==0), all registered.
//   Write accepted iff wr_en && (!full || pop); pop is the FSM read this cycle.
//   Simultaneous accepted write + pop: count unchanged.
//  FSM states / transitions:
//   IDLE:      !empty && !uart_busy -> LOAD.
//   LOAD:      1 cycle; data<=FIFO[rd_ptr], pop (rd_ptr++, count--), up_data=1 -> WAIT_BUSY.
//   WAIT_BUSY: uart_busy -> WAIT_DONE; tmo counter reaches BUSY_TMO -> GAP (byte
//              counted as sent, no retry).
//   WAIT_DONE: !uart_busy -> GAP.
//   GAP:       counts GAP cycles (0 = pass-through in one cycle) -> IDLE.
//  Latency: write on edge k into empty FIFO with UART idle -> up_data high between
//   edges k+2 and k+3 (count valid k+1, IDLE->LOAD at k+2).
//  up_data is exactly one cycle per popped byte; never two pulses without an
//   intervening uart_busy high or BUSY_TMO expiry. Bytes issued in FIFO order.
//  data changes only in LOAD; stable otherwise.
//  uart_busy high while in IDLE (foreign frame) blocks issue; no pop.
//  wr_en while full and no pop: byte dropped, FIFO contents/count untouched.
// CONFIGURATION
//  UART_FEED_OVF_EN defined: ovf port exists; set on any dropped write
//   (wr_en && full && !pop); cleared only by rst.
//  UART_FEED_OVF_EN undefined: ovf port absent; drops are silent. All other
//   behaviour identical.
// TESTING
//  1 rst pulse mid-run -> all outputs at reset values same cycle, empty=1, FSM IDLE.
//  2 write 0xA5 to empty FIFO, uart_busy model rises 2 cyc after up_data, lasts 10
//    -> up_data at k+2, data=0xA5, next pulse none; count 1->0.
//  3 burst 0x01..0x10 (16 writes, DEPTH=16) with UART model -> 16 up_data pulses,
//    data sequence 0x01..0x10 in order, each after busy falls + GAP.
//  4 fill to full, write 0xFF with no pop -> dropped, count=16, ovf=1 (OVF_EN);
//    write coinciding with LOAD pop -> accepted, count stays 16.
//  5 uart_busy tied 0 -> each byte leaves WAIT_BUSY after BUSY_TMO cycles; 3 bytes
//    -> exactly 3 pulses spaced BUSY_TMO+GAP+3 cycles.
//  6 uart_busy held 1 while FIFO non-empty -> no up_data, count constant; release ->
//    pulse within 2 cycles.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that paces host writes into one UART transmitter using its busy flag.
// Define UART_FEED_OVF_EN to add the sticky ovf port that flags dropped writes.
module uart_tx_feeder #(
  parameter int N        = 8,
  parameter int DEPTH    = 16,
  parameter int BUSY_TMO = 15,
  parameter int GAP      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [N-1:0]           wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   uart_busy,
  output logic [N-1:0]           data,
  output logic                   up_data,
  output logic                   tx_active
`ifdef UART_FEED_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (BUSY_TMO > GAP) ? BUSY_TMO : GAP;
  localparam int TW   = $clog2(TMAX + 2);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_next;

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_full;
  logic          r_empty;
  logic [N-1:0]  r_data;

  logic          w_pop;
  logic          w_load;
  logic          w_wr_acc;

  // The FSM pops exactly during its LOAD cycle, which lets a write into a full FIFO land.
  assign w_pop    = (r_state == ST_LOAD);
  assign w_wr_acc = wr_en && (!r_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_acc, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  // One counter serves both the busy-rise timeout and the inter-frame gap.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_empty && !uart_busy) begin
          w_state_next = ST_LOAD;
          w_load       = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_busy) begin
          w_state_next = ST_WAIT_DONE;
        end else if (r_cnt == TMO_LAST) begin
          w_state_next = ST_GAP;
        end else begin
          w_cnt_next = r_cnt + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + TW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Data is captured on entry to LOAD so it is already valid while up_data is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_data <= r_mem[r_rd_ptr];
      end
    end
  end

`ifdef UART_FEED_OVF_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = wr_en && r_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign data      = r_data;
  assign up_data   = (r_state == ST_LOAD);
  assign tx_active = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised bench for uart_tx_feeder: cycle-level reference model built from
// occupancy/timestamp rules, a responsive UART busy model, and directed scenarios.
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int N        = 8;
  localparam int DEPTH    = 16;
  localparam int BUSY_TMO = 15;
  localparam int GAP      = 2;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [N-1:0]  wr_data = '0;
  logic          uart_busy = 1'b0;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [N-1:0]  data;
  logic          up_data;
  logic          tx_active;
`ifdef UART_FEED_OVF_EN
  logic          ovf;
`endif

  uart_tx_feeder #(
    .N(N), .DEPTH(DEPTH), .BUSY_TMO(BUSY_TMO), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .uart_busy(uart_busy),
    .data(data), .up_data(up_data), .tx_active(tx_active)
`ifdef UART_FEED_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO as a queue, feeder timing as timestamps of pulse and idle return.
  logic [N-1:0] m_q[$];
  logic [N-1:0] exp_data = '0;
  logic [N-1:0] m_nd;
  bit exp_ovf = 1'b0;
  bit m_load = 1'b0, m_active = 1'b0, m_open = 1'b0, m_busy_seen = 1'b0;
  bit m_pop, m_full_t, m_load_n;
  int m_p = 0, m_idle_at = -1, m_t;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      exp_data = '0; exp_ovf = 1'b0;
      m_load = 1'b0; m_active = 1'b0; m_open = 1'b0; m_busy_seen = 1'b0;
      m_idle_at = -1;
      cyc = cyc + 1;
    end else begin
      m_t      = cyc;
      m_pop    = m_load;
      m_full_t = (m_q.size() == DEPTH);
      m_load_n = !m_active && (m_q.size() != 0) && !uart_busy;
      m_nd     = (m_q.size() != 0) ? m_q[0] : '0;
      if (m_open && !m_load && m_idle_at < 0) begin
        if (!m_busy_seen) begin
          if (uart_busy) m_busy_seen = 1'b1;
          else if (m_t == m_p + BUSY_TMO) m_idle_at = m_t + GAP + 2;
        end else if (!uart_busy) begin
          m_idle_at = m_t + GAP + 2;
        end
      end
      if (m_pop) m_q.delete(0);
      if (wr_en) begin
        if (!m_full_t || m_pop) m_q.push_back(wr_data);
        else exp_ovf = 1'b1;
      end
      cyc = m_t + 1;
      m_load = m_load_n;
      if (m_load_n) begin
        exp_data = m_nd;
        m_open = 1'b1; m_p = cyc; m_busy_seen = 1'b0; m_idle_at = -1;
      end
      if (m_open && m_idle_at >= 0 && cyc >= m_idle_at) m_open = 1'b0;
      m_active = m_open;
    end
  end

  int pulse_cyc[$];
  logic [N-1:0] pulse_dat[$];

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("count", 32'(count), 32'(m_q.size()));
      chk("full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("up_data", 32'(up_data), 32'(m_load));
      chk("tx_active", 32'(tx_active), 32'(m_active));
      chk("data", 32'(data), 32'(exp_data));
`ifdef UART_FEED_OVF_EN
      chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
      if (up_data === 1'b1) begin
        pulse_cyc.push_back(cyc);
        pulse_dat.push_back(data);
      end
    end
  end

  // UART model: 0 responsive, 1 busy tied low, 2 busy tied high, 3 random responsive.
  int uart_mode = 0;
  int frame_len = 10;
  int rise_cnt = 0, busy_left = 0, cur_len = 10;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      case (uart_mode)
        1: begin uart_busy = 1'b0; rise_cnt = 0; busy_left = 0; end
        2: begin uart_busy = 1'b1; rise_cnt = 0; busy_left = 0; end
        default: begin
          if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) busy_left = cur_len;
          end
          if (uart_mode == 3 && busy_left == 0 && rise_cnt == 0 && $urandom_range(0, 31) == 0)
            busy_left = $urandom_range(1, 6);
          if (busy_left > 0) begin uart_busy = 1'b1; busy_left--; end
          else uart_busy = 1'b0;
          if (up_data === 1'b1) begin
            if (uart_mode == 3) begin
              cur_len = $urandom_range(1, 12);
              if ($urandom_range(0, 7) != 0) rise_cnt = 2;
            end else begin
              cur_len = frame_len;
              rise_cnt = 2;
            end
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [N-1:0] b);
    wr_en = 1'b1; wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(tx_active === 1'b0 && empty === 1'b1 && uart_busy === 1'b0) && n < bound) begin
      tick(); n++;
    end
    chk("idle_wait", 32'(n < bound), 32'd1);
  endtask

  task automatic wait_pulses(input int target, input int bound);
    int n = 0;
    while (pulse_cyc.size() < target && n < bound) begin
      tick(); n++;
    end
    chk("pulse_wait", 32'(pulse_cyc.size() >= target), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int base, c0, n, r, rate;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single byte into an empty FIFO with an idle UART.
    base = pulse_cyc.size();
    c0 = cyc;
    push(8'hA5);
    chk("t2_count1", 32'(count), 32'd1);
    wait_pulses(base + 1, 10);
    chk("t2_latency", 32'(pulse_cyc[base]), 32'(c0 + 2));
    chk("t2_data", 32'(pulse_dat[base]), 32'hA5);
    tick();
    chk("t2_count0", 32'(count), 32'd0);
    wait_idle(100);
    repeat (5) tick();
    chk("t2_one_pulse", 32'(pulse_cyc.size()), 32'(base + 1));

    // Burst of 16 bytes drained in order.
    base = pulse_cyc.size();
    for (int i = 1; i <= 16; i++) push(8'(i));
    wait_pulses(base + 16, 1000);
    for (int i = 0; i < 16; i++)
      if (base + i < pulse_dat.size()) chk("t3_order", 32'(pulse_dat[base + i]), 32'(i + 1));
    wait_idle(200);

    // Fill to full, drop a write, then write during the LOAD pop.
    uart_mode = 2;
    tick(); tick();
    for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
    push(8'hFF);
    chk("t4_count_full", 32'(count), 32'd16);
    chk("t4_full", 32'(full), 32'd1);
`ifdef UART_FEED_OVF_EN
    chk("t4_ovf", 32'(ovf), 32'd1);
`endif
    frame_len = 10;
    uart_mode = 0;
    n = 0;
    while (up_data !== 1'b1 && n < 10) begin tick(); n++; end
    chk("t4_load_seen", 32'(up_data), 32'd1);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("t4_count_pop_wr", 32'(count), 32'd16);
    wait_idle(2000);

    // UART never answers: every byte times out.
    uart_mode = 1;
    tick(); tick();
    base = pulse_cyc.size();
    push(8'h31); push(8'h32); push(8'h33);
    wait_pulses(base + 3, 300);
    if (pulse_cyc.size() >= base + 3) begin
      chk("t5_space1", 32'(pulse_cyc[base + 1] - pulse_cyc[base]), 32'(BUSY_TMO + GAP + 3));
      chk("t5_space2", 32'(pulse_cyc[base + 2] - pulse_cyc[base + 1]), 32'(BUSY_TMO + GAP + 3));
    end
    wait_idle(200);
    repeat (40) tick();
    chk("t5_three_pulses", 32'(pulse_cyc.size()), 32'(base + 3));

    // Foreign frame holds busy: nothing issues until release.
    uart_mode = 2;
    tick(); tick();
    base = pulse_cyc.size();
    push(8'h11); push(8'h22);
    repeat (20) tick();
    chk("t6_count_held", 32'(count), 32'd2);
    chk("t6_no_pulse", 32'(pulse_cyc.size()), 32'(base));
    uart_mode = 0;
    n = 0;
    while (uart_busy !== 1'b0 && n < 5) begin tick(); n++; end
    r = cyc;
    wait_pulses(base + 1, 5);
    if (pulse_cyc.size() > base) chk("t6_release_lat", 32'(pulse_cyc[base] - r <= 2), 32'd1);
    wait_idle(200);

    // Reset in the middle of a transfer.
    base = pulse_cyc.size();
    push(8'h3C); push(8'h4D); push(8'h5E); push(8'h6F);
    wait_pulses(base + 1, 20);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("t1_up_data", 32'(up_data), 32'd0);
    chk("t1_tx_active", 32'(tx_active), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_full", 32'(full), 32'd0);
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_data", 32'(data), 32'd0);
`ifdef UART_FEED_OVF_EN
    chk("t1_ovf", 32'(ovf), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Random traffic against the reference model.
    uart_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 10;
          1: rate = 40;
          default: rate = 90;
        endcase
      end
      wr_en = ($urandom_range(0, 99) < rate);
      wr_data = 8'($urandom_range(0, 255));
      tick();
    end
    wr_en = 1'b0;
    uart_mode = 0;
    wait_idle(5000);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
